pc_fetch_gen: RTL
=================

// Module: pc_fetch_gen
// PURPOSE
//  Next-generation PC generator for the fetch stage: issues FETCH_WIDTH-instruction fetch groups to the
//  I-side over a valid/ready handshake and applies redirects with fixed priority (eret > exception >
//  mispredict > prediction > sequential). Holds any redirect that lands on a stalled request.
//  A RAS_DEPTH-entry return address stack supplies return targets. Sits between the branch predictor / commit
//  redirect logic and the I-cache request port.
// PARAMETERS
//  RESET_ADDR   32'hbfc0_0000  PC presented first after reset
//  EXEC_ADDR    32'hbfc0_0380  exception entry vector
//  FETCH_WIDTH  2              instructions per fetch group; power of two, 1..4
//  RAS_DEPTH    4              return address stack entries; power of two, >=2
// PORTS
//  clk           in   1            clock; all state on rising edge
//  reset         in   1            asynchronous, active-high reset
//  stall         in   1            pipeline stall: sequential/prediction advance suppressed
//  eret          in   1            eret committed: redirect to epc
//  epc           in   32           eret target
//  exc_oc        in   1            exception committed: redirect to EXEC_ADDR
//  pred_fail     in   1            mispredict resolved: redirect to real_target
//  real_target   in   32           corrected target
//  bp_taken      in   1            predictor: current accepted group redirects
//  bp_target     in   32           predicted target
//  bp_call       in   1            with bp_taken: push bp_link onto RAS
//  bp_ret        in   1            with bp_taken: target = RAS top (pop)
//  bp_link       in   32           return address for call (call pc + 8)
//  fetch_pc      out  32           fetch group address
//  fetch_valid   out  1            request valid
//  fetch_ready   in   1            I-side accepts request this cycle
//  fetch_mask    out  FETCH_WIDTH  bit i = slot i of the group is on-path (pc[GW-1:2] <= i)
//  fetch_kill    out  1            1-cycle pulse: discard all in-flight fetch data
// BEHAVIOUR
//  - Reset: fetch_pc=RESET_ADDR, fetch_valid=0, fetch_mask=0, fetch_kill=0, RAS count=0, ptr=0, state=BOOT.
//  - States:
//    - BOOT -> RUN after one cycle (fetch_valid rises the first cycle after reset deasserts).
//    - RUN: request presented.
//    - HOLD: redirect pending behind an unaccepted request.
//  - Handshake: while fetch_valid & !fetch_ready, fetch_pc and fetch_mask are stable. Transfer = valid & ready.
//  - Group size G = FETCH_WIDTH*4 bytes.
//    - Sequential next = (fetch_pc & ~(G-1)) + G, 32-bit wrap (0xFFFF_FFF8 + 8 -> 0).
//    - fetch_mask derives from fetch_pc[log2(G)-1:2].
//  - Next-PC select, evaluated each cycle in RUN, highest first:
//    1. eret -> epc
//    2. exc_oc -> EXEC_ADDR
//    3. pred_fail -> real_target
//    4. transfer & !stall & bp_taken -> (bp_ret & RAS nonempty) ? RAS top : bp_target
//    5. transfer & !stall -> sequential
//    6. else hold
//  - Redirect timing for eret/exc_oc/pred_fail:
//    - with transfer, or with fetch_valid=0: fetch_pc loads the target next cycle, fetch_kill pulses the
//      next cycle. These three ignore stall.
//    - without transfer: latch target into pend_pc and go to HOLD. fetch_pc stays unchanged until transfer.
//      On transfer, fetch_pc=pend_pc, fetch_kill pulses, return to RUN.
//  - Redirects in HOLD: a newer eret/exc/pred_fail overwrites pend_pc, with the same priority.
//    Predictions and sequential advance are ignored in HOLD.
//  - Prediction redirects never raise fetch_kill.
//  - RAS: acts only on transfer & !stall & bp_taken.
//    - Call: push bp_link. When full, overwrite the oldest entry circularly; count saturates at RAS_DEPTH.
//    - Ret: pop when count>0; on empty, use bp_target and leave the state unchanged.
//    - Call and ret together: pop, then push (net replace top).
//    - RAS is not repaired on eret/exc/pred_fail.
//  - Reset asserted mid-HOLD or mid-transfer: immediate return to reset values; the pending target is lost.
// STRUCTURE
//  - Shared package/header: RESET_ADDR and EXEC_ADDR defaults, state encodings (BOOT/RUN/HOLD),
//    redirect-cause encoding.
//  - One sub-module: pc_ras (RAS_DEPTH-deep circular stack with push/pop/top/count). The rest is inline.
// TESTING
//  1. Reset release, FETCH_WIDTH=2, ready=1 -> fetch_pc 0xbfc00000, then ..08, then ..10; mask=2'b11.
//  2. Unaligned redirect: pred_fail to 0xbfc00104 -> mask=2'b10, kill pulse, next pc 0xbfc00108.
//  3. exc_oc while valid & !ready for 3 cycles -> fetch_pc held, then 0xbfc00380 after accept,
//     one kill pulse; a later eret in HOLD overrides to epc.
//  4. Simultaneous eret and exc_oc and pred_fail -> epc wins.
//     stall=1 with bp_taken -> no advance, no RAS change.
//  5. RAS_DEPTH=4: 5 calls (links A..E), then 5 rets -> targets E,D,C,B, then bp_target (empty).
//  6. Sequential wrap at 0xFFFFFFF8 -> 0x00000000.
//     Async reset mid-HOLD -> fetch_pc=RESET_ADDR without waiting for clk.

Source files
------------

// File: rtl/pc_fetch_gen_pkg.sv
// Shared definitions for the fetch PC generator: default vectors, FSM states,
// redirect-cause encoding and the fetch-group slot mask helper.
package pc_fetch_gen_pkg;

    localparam logic [31:0] RESET_ADDR_DEF = 32'hbfc0_0000;
    localparam logic [31:0] EXEC_ADDR_DEF  = 32'hbfc0_0380;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    typedef enum logic [2:0] {
        RC_HOLD = 3'd0,
        RC_SEQ  = 3'd1,
        RC_PRED = 3'd2,
        RC_MISP = 3'd3,
        RC_EXC  = 3'd4,
        RC_ERET = 3'd5
    } redir_cause_e;

    // Slot 'slot' is on-path when the group offset of pc does not lie beyond it.
    function automatic logic slot_on_path(input logic [31:0] pc,
                                          input int unsigned fw,
                                          input int unsigned slot);
        logic [31:0] off;
        logic        on;
        off = (pc >> 2) & (fw - 32'd1);
        if (off <= slot) begin
            on = 1'b1;
        end else begin
            on = 1'b0;
        end
        return on;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return address stack: a push when full overwrites the oldest entry
// and the count saturates at DEPTH.
module pc_ras #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [31:0]                push_data,
    output logic [31:0]                top,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   mem_d [DEPTH];
    logic [PW-1:0] ptr_q, ptr_d, top_idx_s;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_pop_s;

    // Next stack state; pop-then-push collapses to rewriting the top entry.
    always_comb begin
        mem_d     = mem_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        top_idx_s = ptr_q - PW'(1);
        do_pop_s  = pop && (cnt_q != '0);
        if (do_pop_s && push) begin
            mem_d[top_idx_s] = push_data;
        end else if (do_pop_s) begin
            ptr_d = top_idx_s;
            cnt_d = cnt_q - CW'(1);
        end else if (push) begin
            mem_d[ptr_q] = push_data;
            ptr_d        = ptr_q + PW'(1);
            if (cnt_q != CW'(DEPTH)) begin
                cnt_d = cnt_q + CW'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Stack storage, pointer and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 32'h0000_0000;
            end
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    assign top   = mem_q[top_idx_s];
    assign count = cnt_q;

endmodule

// File: rtl/pc_fetch_gen.sv
// Fetch-stage next-PC generator: prioritised redirects, valid/ready request
// port, redirect parking behind a stalled request, and RAS-backed returns.
module pc_fetch_gen
    import pc_fetch_gen_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR  = RESET_ADDR_DEF,
    parameter logic [31:0] EXEC_ADDR   = EXEC_ADDR_DEF,
    parameter int unsigned FETCH_WIDTH = 2,
    parameter int unsigned RAS_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   eret,
    input  logic [31:0]            epc,
    input  logic                   exc_oc,
    input  logic                   pred_fail,
    input  logic [31:0]            real_target,
    input  logic                   bp_taken,
    input  logic [31:0]            bp_target,
    input  logic                   bp_call,
    input  logic                   bp_ret,
    input  logic [31:0]            bp_link,
    output logic [31:0]            fetch_pc,
    output logic                   fetch_valid,
    input  logic                   fetch_ready,
    output logic [FETCH_WIDTH-1:0] fetch_mask,
    output logic                   fetch_kill
);
    localparam logic [31:0] GROUP_BYTES = 32'(FETCH_WIDTH * 4);
    localparam int unsigned CW          = $clog2(RAS_DEPTH + 1);

    fetch_state_e           state_q, state_d;
    logic [31:0]            fetch_pc_q, fetch_pc_d;
    logic [31:0]            pend_pc_q, pend_pc_d;
    logic                   fetch_valid_q, fetch_valid_d;
    logic                   fetch_kill_q, fetch_kill_d;
    logic [FETCH_WIDTH-1:0] fetch_mask_q, fetch_mask_d;

    redir_cause_e  cause_s;
    logic          xfer_s, redir_s;
    logic [31:0]   next_tgt_s, hold_tgt_s, seq_pc_s, ras_top_s;
    logic          ras_push_s, ras_pop_s;
    logic [CW-1:0] ras_count_s;

    pc_ras #(.DEPTH(RAS_DEPTH)) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push_s),
        .pop       (ras_pop_s),
        .push_data (bp_link),
        .top       (ras_top_s),
        .count     (ras_count_s)
    );

    // Winning redirect cause and its target, highest priority first.
    always_comb begin
        xfer_s   = fetch_valid_q & fetch_ready;
        redir_s  = eret | exc_oc | pred_fail;
        seq_pc_s = (fetch_pc_q & ~(GROUP_BYTES - 32'd1)) + GROUP_BYTES;
        if (eret) begin
            cause_s    = RC_ERET;
            next_tgt_s = epc;
        end else if (exc_oc) begin
            cause_s    = RC_EXC;
            next_tgt_s = EXEC_ADDR;
        end else if (pred_fail) begin
            cause_s    = RC_MISP;
            next_tgt_s = real_target;
        end else if (xfer_s && !stall && bp_taken) begin
            cause_s = RC_PRED;
            if (bp_ret && (ras_count_s != '0)) begin
                next_tgt_s = ras_top_s;
            end else begin
                next_tgt_s = bp_target;
            end
        end else if (xfer_s && !stall) begin
            cause_s    = RC_SEQ;
            next_tgt_s = seq_pc_s;
        end else begin
            cause_s    = RC_HOLD;
            next_tgt_s = fetch_pc_q;
        end
    end

    // Request FSM: the presented request never changes until accepted, so a
    // committed redirect arriving against a stalled request is parked in pend_pc.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        pend_pc_d     = pend_pc_q;
        fetch_valid_d = fetch_valid_q;
        fetch_kill_d  = 1'b0;
        ras_push_s    = 1'b0;
        ras_pop_s     = 1'b0;
        hold_tgt_s    = redir_s ? next_tgt_s : pend_pc_q;
        case (state_q)
            ST_BOOT: begin
                state_d       = ST_RUN;
                fetch_valid_d = 1'b1;
                if (redir_s) begin
                    fetch_pc_d   = next_tgt_s;
                    fetch_kill_d = 1'b1;
                end else begin
                    fetch_pc_d = fetch_pc_q;
                end
            end
            ST_RUN: begin
                case (cause_s)
                    RC_ERET, RC_EXC, RC_MISP: begin
                        if (xfer_s || !fetch_valid_q) begin
                            fetch_pc_d   = next_tgt_s;
                            fetch_kill_d = 1'b1;
                        end else begin
                            pend_pc_d = next_tgt_s;
                            state_d   = ST_HOLD;
                        end
                    end
                    RC_PRED: begin
                        fetch_pc_d = next_tgt_s;
                        ras_push_s = bp_call;
                        ras_pop_s  = bp_ret;
                    end
                    RC_SEQ:  fetch_pc_d = next_tgt_s;
                    default: fetch_pc_d = fetch_pc_q;
                endcase
            end
            ST_HOLD: begin
                if (xfer_s) begin
                    fetch_pc_d   = hold_tgt_s;
                    fetch_kill_d = 1'b1;
                    state_d      = ST_RUN;
                end else begin
                    pend_pc_d = hold_tgt_s;
                end
            end
            default: begin
                state_d       = ST_BOOT;
                fetch_valid_d = 1'b0;
            end
        endcase
        for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
            if (fetch_valid_d) begin
                fetch_mask_d[i] = slot_on_path(fetch_pc_d, FETCH_WIDTH, i);
            end else begin
                fetch_mask_d[i] = 1'b0;
            end
        end
    end

    // Registered FSM state and request outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_BOOT;
            fetch_pc_q    <= RESET_ADDR;
            pend_pc_q     <= RESET_ADDR;
            fetch_valid_q <= 1'b0;
            fetch_kill_q  <= 1'b0;
            fetch_mask_q  <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            pend_pc_q     <= pend_pc_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_kill_q  <= fetch_kill_d;
            fetch_mask_q  <= fetch_mask_d;
        end
    end

    assign fetch_pc    = fetch_pc_q;
    assign fetch_valid = fetch_valid_q;
    assign fetch_mask  = fetch_mask_q;
    assign fetch_kill  = fetch_kill_q;

endmodule
